// File: rtl/instr_fetch_queue.sv
// ============================================================================
// instr_fetch_queue
// ----------------------------------------------------------------------------
// RV32I fetch stage that sits directly in front of the instruction splitter.
// It owns the program counter, issues one word fetch at a time to
// instruction memory, and buffers the returned words together with their
// PCs in a small in-order FIFO. Decode drains the FIFO through a
// valid/ready handshake. A redirect (branch/jump) flushes the FIFO,
// reloads the PC and discards any fetch that is still in flight.
//
// Parameters
//   RESET_PC        PC loaded on reset (word aligned)
//   DEPTH           FIFO entries (power of two, >= 2)
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   imem_req        fetch request (combinational)
//   imem_addr       fetch byte address (the PC register)
//   imem_gnt        memory accepts the request this cycle
//   imem_rvalid     read data valid (in order, >= 1 cycle after grant)
//   imem_rdata      returned instruction word
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address (bits [1:0] forced to zero)
//   instr_valid     FIFO head valid for decode
//   instr_ready     decode accepts the head
//   instr           head instruction word
//   instr_pc        PC of the head instruction
// ============================================================================
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [31:0]      r_pc;
    logic [31:0]      r_reqPc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic             r_outstanding;
    logic             r_drop;

    logic [31:0]      r_instrMem [DEPTH];
    logic [31:0]      r_pcMem    [DEPTH];

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    logic        w_grant;
    logic        w_resp;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_redirectAligned;
    logic [31:0] w_pcPlus4;

    // Redirect target is forced word aligned; masking keeps every bit used.
    assign w_redirectAligned = redirect_pc & 32'hFFFF_FFFC;
    assign w_pcPlus4         = r_pc + 32'd4;

    // Only one fetch may be in flight, and the occupancy check uses the
    // registered count so a returning word always finds a free slot. The
    // rst_n term keeps the request low while reset is held, since the
    // cleared state alone would otherwise request immediately.
    assign imem_req  = rst_n && !r_outstanding && (r_count < FULL_COUNT)
                       && !redirect_valid;
    assign imem_addr = r_pc;

    assign w_grant = imem_req && imem_gnt;

    // A response only counts while a fetch is outstanding; stray rvalids
    // (e.g. just after reset) are ignored.
    assign w_resp = imem_rvalid && r_outstanding;

    // Words fetched before a redirect are discarded, either because the
    // redirect coincides with the response or because drop was armed.
    assign w_push = w_resp && !r_drop && !redirect_valid;

    // The head is hidden during a redirect, so a pop can never coincide
    // with a flush.
    assign instr_valid = rst_n && (r_count != '0) && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;

    // Combinational head read; contents are don't-care when empty.
    assign instr    = r_instrMem[r_rdPtr];
    assign instr_pc = r_pcMem[r_rdPtr];

    // ------------------------------------------------------------------------
    // PC, request tracking and drop flag
    // ------------------------------------------------------------------------
    // Redirect wins over everything else. When a fetch is still in flight
    // and its response is not arriving this cycle, drop is armed so that
    // the late word is thrown away. A response arriving alongside the
    // redirect is consumed here and discarded by w_push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_reqPc       <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= w_redirectAligned;
            if (w_resp) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end else if (r_outstanding) begin
                r_drop <= 1'b1;
            end
        end else begin
            if (w_grant) begin
                r_outstanding <= 1'b1;
                r_reqPc       <= r_pc;
                r_pc          <= w_pcPlus4;
            end
            if (w_resp) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    // A flush resets pointers and count. Otherwise simultaneous push and pop
    // leave the count alone, which is legal even when full because the pop
    // frees the slot the push lands in on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else if (redirect_valid) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------------
    // Storage needs no reset: entries are only observed through r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= imem_rdata;
            r_pcMem[r_wrPtr]    <= r_reqPc;
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- RV32I fetch stage that sits directly upstream of the instruction splitter (decode).
- Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions, with their PCs, in a small in-order FIFO.
- Presents them to decode through a valid/ready handshake and supports redirect (branch/jump) with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request (combinational).
- imem_addr  out  32  fetch byte address; equals the PC register.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid, at least 1 cycle after the grant; responses are in order.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  FIFO head is valid for decode.
- instr_ready  in  1  decode accepts the head.
- instr  out  32  head instruction word, fed to the splitter.
- instr_pc  out  32  PC of the head instruction.

Behaviour:
- Reset (async, rst_n=0), applied immediately:
  - pc=RESET_PC, count=0, rd/wr pointers=0, outstanding=0, drop=0.
  - imem_req=0 and instr_valid=0 while rst_n=0.
  - Reset mid-transaction abandons the transaction; any rvalid seen in the first cycle after reset is ignored because outstanding=0.
- Request issue:
  - imem_req = !outstanding && (count < DEPTH) && !redirect_valid.
  - This allows at most one outstanding fetch.
  - The occupancy check uses registered count, so a returning word always has a free slot.
- Grant:
  - On imem_req && imem_gnt: outstanding<=1, pc<=pc+4 (32-bit wrap-around, FFFF_FFFC -> 0000_0000).
  - The PC of the request is recorded in req_pc.
  - While imem_gnt=0, imem_req and imem_addr stay stable.
- Response:
  - On imem_rvalid && outstanding: outstanding<=0.
  - If drop=0 and no redirect this cycle: push {imem_rdata, req_pc}.
  - Otherwise discard the word and clear drop.
  - imem_rvalid with outstanding=0 is ignored.
- Output:
  - instr_valid = (count != 0) && !redirect_valid.
  - instr and instr_pc come from the head entry (combinational read).
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged; this is legal even when full.
  - With count=0 there is no bypass: a returned word first appears on instr_valid the cycle after rvalid.
- Throughput:
  - With a 1-cycle memory and gnt=1, one request every 2 cycles (req, rvalid, req, ...).
  - Latency from grant to instr_valid is 2 cycles.
- Redirect (redirect_valid=1 in a cycle):
  - FIFO flushed: count<=0, pointers reset.
  - Any pop in that cycle is ignored.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - imem_req=0 in the redirect cycle.
  - If outstanding and no rvalid this cycle: drop<=1 (the next response is discarded).
  - If rvalid arrives in the same cycle: the word is discarded and outstanding<=0.
  - Redirect has priority over every other event in that cycle.
  - Back-to-back redirects: the last one wins.
  - drop is never set twice, because outstanding is at most 1.
- Full FIFO (count=DEPTH): imem_req=0 until a pop occurs.
- Empty FIFO: instr_valid=0; instr and instr_pc are don't-care.

Test Plan:
- Reset with RESET_PC=0x100; memory has 1-cycle latency, gnt=1, instr_ready=1.
  - Required: imem_addr sequence 0x100, 0x104, 0x108 on successive request cycles.
  - Required: decode receives (0x100, word0), (0x104, word1), ... in order, each instr_valid pulse 2 cycles apart.
- instr_ready=0 for 10 cycles after reset.
  - Required: exactly DEPTH=2 grants, then imem_req=0 with count=2.
  - On raising ready: PCs 0x100, 0x104 pop, then fetch resumes at 0x108.
- Redirect to 0x2003 in the cycle after a grant to 0x108, with rvalid arriving the next cycle.
  - Required: that word is dropped and the FIFO is flushed.
  - Required: next imem_addr=0x2000 and the next instr_pc=0x2000.
- Redirect in the same cycle as rvalid.
  - Required: the word is not pushed, instr_valid=0 in that cycle.
  - Required: a request to the redirect target occurs the following cycle.
- PC wrap: redirect to 0xFFFF_FFFC.
  - Required: fetches to 0xFFFF_FFFC then 0x0000_0000; instr_pc values match.
- Assert rst_n=0 asynchronously while outstanding=1 with a FIFO entry held.
  - Required: imem_req=0 and instr_valid=0 immediately.
  - Required: after release, fetch restarts at RESET_PC and a stray rvalid is ignored.
